// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, branch squash,
// data-memory wait FSM with timeout, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int M       = 4,
  parameter int TIMEOUT = 64,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_D,
  input  logic [M-1:0]  rs1_D,
  input  logic [M-1:0]  rs2_D,
  input  logic          use1_D,
  input  logic          use2_D,
  input  logic          vec_D,
  input  logic [M-1:0]  regdst_E,
  input  logic          regw_E,
  input  logic          regmem_E,
  input  logic          vec_E,
  input  logic          branch_E,
  input  logic          memreq_M,
  input  logic          mem_ready,
  output logic          en_F,
  output logic          en_D,
  output logic          en_E,
  output logic          en_M,
  output logic          flush_D,
  output logic          flush_E,
  output logic          bubble_W,
  output logic          mem_err,
  output logic [CW-1:0] stall_cnt
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          mem_err_q, mem_err_d;
  logic [CW-1:0] stall_q, stall_d;

  logic hit1_s, hit2_s, lu_s, mw_s;

  // Hazard detection; scalar register 0 is hardwired so it never creates a dependency
  always_comb begin
    hit1_s = use1_D & (rs1_D == regdst_E) & (vec_D | (rs1_D != {M{1'b0}}));
    hit2_s = use2_D & (rs2_D == regdst_E) & (vec_D | (rs2_D != {M{1'b0}}));
    lu_s   = valid_D & regw_E & regmem_E & (vec_D == vec_E) & (hit1_s | hit2_s);
    mw_s   = memreq_M & ~mem_ready;
  end

  // Pipeline control decode, priority ERR > memory wait > branch > load-use
  always_comb begin
    en_F     = 1'b1;
    en_D     = 1'b1;
    en_E     = 1'b1;
    en_M     = 1'b1;
    flush_D  = 1'b0;
    flush_E  = 1'b0;
    bubble_W = 1'b0;
    if (rst) begin
      flush_D  = 1'b1;
      flush_E  = 1'b1;
      bubble_W = 1'b1;
    end else if ((state_q == ERR) || mw_s) begin
      // A pending branch stays in E and is flushed on the release cycle
      en_F     = 1'b0;
      en_D     = 1'b0;
      en_E     = 1'b0;
      en_M     = 1'b0;
      bubble_W = 1'b1;
    end else if (branch_E) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (lu_s) begin
      en_F    = 1'b0;
      en_D    = 1'b0;
      flush_E = 1'b1;
    end else begin
      en_F = 1'b1;
    end
  end

  // Wait FSM, sticky error and stall counter next-state
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_err_d = mem_err_q;
    if (!en_F && (stall_q != {CW{1'b1}})) begin
      stall_d = stall_q + CW'(1);
    end else begin
      stall_d = stall_q;
    end
    case (state_q)
      RUN: begin
        if (mw_s) begin
          wcnt_d = WW'(1);
          if (TIMEOUT <= 1) begin
            state_d   = ERR;
            mem_err_d = 1'b1;
          end else begin
            state_d = MEMWAIT;
          end
        end else begin
          wcnt_d = {WW{1'b0}};
        end
      end
      MEMWAIT: begin
        // Ready or an illegally dropped request both release back to RUN
        if (mw_s) begin
          wcnt_d = wcnt_q + WW'(1);
          if (wcnt_q == WAIT_LAST) begin
            state_d   = ERR;
            mem_err_d = 1'b1;
          end else begin
            state_d = MEMWAIT;
          end
        end else begin
          state_d = RUN;
          wcnt_d  = {WW{1'b0}};
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = RUN;
        wcnt_d  = {WW{1'b0}};
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wcnt_q    <= {WW{1'b0}};
      mem_err_q <= 1'b0;
      stall_q   <= {CW{1'b0}};
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level reference model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int M  = 4;
  localparam int TO = 4;
  localparam int CW = 8;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          valid_D, use1_D, use2_D, vec_D;
  logic [M-1:0]  rs1_D, rs2_D, regdst_E;
  logic          regw_E, regmem_E, vec_E, branch_E, memreq_M, mem_ready;
  logic          en_F, en_D, en_E, en_M, flush_D, flush_E, bubble_W, mem_err;
  logic [CW-1:0] stall_cnt;

  pipe_hazard_ctrl #(.M(M), .TIMEOUT(TO), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .valid_D(valid_D), .rs1_D(rs1_D), .rs2_D(rs2_D), .use1_D(use1_D), .use2_D(use2_D),
    .vec_D(vec_D), .regdst_E(regdst_E), .regw_E(regw_E), .regmem_E(regmem_E),
    .vec_E(vec_E), .branch_E(branch_E), .memreq_M(memreq_M), .mem_ready(mem_ready),
    .en_F(en_F), .en_D(en_D), .en_E(en_E), .en_M(en_M),
    .flush_D(flush_D), .flush_E(flush_E), .bubble_W(bubble_W),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit         m_err   = 1'b0;
  int         m_waits = 0;
  int         m_stall = 0;
  logic [6:0] exp_ctl;
  int         base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit src_hit(input logic u, input logic [M-1:0] idx);
    return (u === 1'b1) && (idx == regdst_E) && ((vec_D === 1'b1) || (idx != 0));
  endfunction

  // expected {en_F,en_D,en_E,en_M,flush_D,flush_E,bubble_W}
  function automatic logic [6:0] model_ctl();
    bit lu, mw;
    mw = memreq_M && !mem_ready;
    lu = valid_D && regw_E && regmem_E && (vec_D == vec_E) &&
         (src_hit(use1_D, rs1_D) || src_hit(use2_D, rs2_D));
    if (rst)      return 7'b1111111;
    if (m_err)    return 7'b0000001;
    if (mw)       return 7'b0000001;
    if (branch_E) return 7'b1111110;
    if (lu)       return 7'b0011010;
    return 7'b1111000;
  endfunction

  task automatic cycle();
    @(negedge clk);
    exp_ctl = model_ctl();
    check("ctl", {25'b0, en_F, en_D, en_E, en_M, flush_D, flush_E, bubble_W}, {25'b0, exp_ctl});
    check("mem_err", 32'(mem_err), 32'(m_err));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    @(posedge clk);
    if (rst) begin
      m_err = 1'b0; m_waits = 0; m_stall = 0;
    end else begin
      if (!exp_ctl[6] && m_stall < SAT) m_stall++;
      if (!m_err) begin
        if (memreq_M && !mem_ready) begin
          m_waits++;
          if (m_waits >= TO) m_err = 1'b1;
        end else begin
          m_waits = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    valid_D = 1'b1; use1_D = 1'b0; use2_D = 1'b0; vec_D = 1'b0;
    rs1_D = '0; rs2_D = '0; regdst_E = '0;
    regw_E = 1'b0; regmem_E = 1'b0; vec_E = 1'b0; branch_E = 1'b0;
    memreq_M = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_load_use(input logic [M-1:0] idx, input logic vd, input logic ve);
    regw_E = 1'b1; regmem_E = 1'b1; regdst_E = idx; rs1_D = idx; use1_D = 1'b1;
    vec_D = vd; vec_E = ve;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    check("reset_stall", 32'(stall_cnt), 32'd0);
    check("reset_err", 32'(mem_err), 32'd0);

    // load-use on scalar r3: one bubble
    set_load_use(4'd3, 1'b0, 1'b0); cycle();
    idle(); cycle();
    check("lu_stall", 32'(stall_cnt), 32'd1);

    // scalar/vector mismatch, scalar r0, vector v0
    set_load_use(4'd3, 1'b1, 1'b0); cycle();
    set_load_use(4'd0, 1'b0, 1'b0); cycle();
    check("no_lu_stall", 32'(stall_cnt), 32'd1);
    set_load_use(4'd0, 1'b1, 1'b1); cycle();
    idle(); cycle();
    check("vec0_stall", 32'(stall_cnt), 32'd2);
    set_load_use(4'd5, 1'b0, 1'b0); use1_D = 1'b0; rs2_D = 4'd5; use2_D = 1'b1; cycle();
    idle(); cycle();

    // memory wait: 3 stalled cycles then release
    base = m_stall;
    memreq_M = 1'b1; mem_ready = 1'b0;
    repeat (3) cycle();
    mem_ready = 1'b1; cycle();
    idle(); cycle();
    check("mw_stall", 32'(stall_cnt), 32'(base + 3));

    // branch held in E during a 2-cycle wait
    branch_E = 1'b1; memreq_M = 1'b1; mem_ready = 1'b0;
    repeat (2) cycle();
    mem_ready = 1'b1; cycle();
    idle(); cycle();

    // branch with simultaneous load-use: flush, no stall
    base = m_stall;
    set_load_use(4'd7, 1'b0, 1'b0); branch_E = 1'b1; cycle();
    idle(); cycle();
    check("br_lu_stall", 32'(stall_cnt), 32'(base));

    // illegal request drop in MEMWAIT returns to RUN without error
    memreq_M = 1'b1; mem_ready = 1'b0; repeat (2) cycle();
    memreq_M = 1'b0; cycle();
    memreq_M = 1'b1; repeat (3) cycle();
    idle(); cycle();
    check("drop_no_err", 32'(mem_err), 32'd0);

    // timeout into ERR, sticky, then saturation of the stall counter
    memreq_M = 1'b1; mem_ready = 1'b0;
    repeat (6) cycle();
    check("timeout_err", 32'(mem_err), 32'd1);
    idle(); mem_ready = 1'b1; memreq_M = 1'b1; branch_E = 1'b1; repeat (4) cycle();
    idle(); repeat (SAT) cycle();
    check("stall_sat", 32'(stall_cnt), 32'(SAT));
    rst = 1'b1; cycle();
    rst = 1'b0;
    check("err_cleared", 32'(mem_err), 32'd0);
    check("stall_cleared", 32'(stall_cnt), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 149) == 0);
      valid_D   = 1'($urandom_range(0, 7) != 0);
      rs1_D     = M'($urandom_range(0, 3));
      rs2_D     = M'($urandom_range(0, 3));
      use1_D    = 1'($urandom_range(0, 1));
      use2_D    = 1'($urandom_range(0, 1));
      vec_D     = 1'($urandom_range(0, 1));
      regdst_E  = M'($urandom_range(0, 3));
      regw_E    = 1'($urandom_range(0, 3) != 0);
      regmem_E  = 1'($urandom_range(0, 1));
      vec_E     = 1'($urandom_range(0, 1));
      branch_E  = 1'($urandom_range(0, 4) == 0);
      memreq_M  = 1'($urandom_range(0, 2) == 0);
      mem_ready = 1'($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
